if_fetch_ctrl: RTL and testbench
================================

Name: if_fetch_ctrl

Overview:
- Instruction-fetch sequencer for the RV32I core.
- Owns the program counter and drives the word address into the combinational instruction ROM (256 x 32, async read).
- Captures fetched words into a small prefetch FIFO and hands {inst, pc} to decode over a valid/ready handshake.
- Handles branch/jump redirects with a flush, and out-of-range and misaligned-target conditions.

Parameters:
- ADDR_W, 8, ROM word-address width (ROM depth = 2**ADDR_W words)
- XLEN, 32, PC and instruction width
- RESET_PC, 32'h0000_0000, PC loaded on reset
- FIFO_DEPTH, 2, prefetch entries (power of two, >= 2)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- fetch_en  in  1  1 = fetching allowed; 0 = hold PC, FIFO keeps draining
- rom_addr  out  ADDR_W  ROM word address = pc[ADDR_W+1:2]
- rom_data  in  XLEN  ROM read data, valid in the same cycle as rom_addr
- redirect_valid  in  1  single-cycle pulse: load redirect_pc and flush
- redirect_pc  in  XLEN  byte address of the new fetch target
- inst_valid  out  1  FIFO head valid
- inst  out  XLEN  FIFO head instruction
- inst_pc  out  XLEN  byte PC of the FIFO head
- inst_ready  in  1  decode accepts head when inst_valid & inst_ready
- err_misalign  out  1  sticky; set when redirect_pc[1:0] != 0
- err_oob  out  1  sticky; set when fetching pc >= 4*2**ADDR_W

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, FIFO empty, inst_valid=0, inst=0, inst_pc=0, err_*=0, state=BOOT.
- FSM states:
  - BOOT: one idle cycle after rst_n rises; no fetch. Goes to RUN if fetch_en, else HALT.
  - RUN: fetch_en=0 moves to HALT.
  - HALT: fetch_en=1 moves to RUN.
  - Redirect is legal in every state and does not change state.
- Fetch condition: state==RUN & !redirect_valid & (fifo not full | pop this cycle).
  - On fetch: push {rom_data, pc}, then pc += 4 (XLEN wrap-around, no saturation).
  - Push and pop in the same cycle are allowed with a full FIFO (count unchanged).
- Latency:
  - First instruction is visible on inst_valid 2 cycles after reset release with fetch_en=1 (BOOT, then push).
  - Steady-state throughput is 1 instruction/cycle while inst_ready=1.
- Head outputs are registered FIFO contents; inst/inst_pc hold while inst_valid & !inst_ready.
- rom_addr is combinational from pc and is always driven; it is also driven in BOOT and HALT.
- Redirect (highest priority):
  - Flush all FIFO entries, so inst_valid=0 next cycle.
  - pc <= {redirect_pc[XLEN-1:2], 2'b00}.
  - No push that cycle; any pop that cycle is ignored, and the head is discarded even if inst_ready=1.
  - If redirect_pc[1:0] != 0, set err_misalign.
- Out-of-range: if pc[XLEN-1:ADDR_W+2] != 0 at fetch, push 32'h00000013 (NOP) with the real pc instead of rom_data, and set err_oob. rom_addr still shows the truncated bits.
- Sticky errors clear only on reset.
- Reset asserted mid-operation returns to the reset state immediately, including a half-accepted handshake.

Optional Feature:
- Macro: IF_FETCH_PERF_EN.
- When defined, adds two outputs:
  - perf_fetch_cnt [31:0]: pushes.
  - perf_stall_cnt [31:0]: cycles in RUN with the FIFO full and no pop.
  - Both reset to 0 and wrap on overflow.
- When undefined, neither the ports nor the counters exist.

Decomposition:
- Package if_pkg holds:
  - NOP_INSN = 32'h00000013
  - fetch_state_e {BOOT, RUN, HALT}
  - typedef fetch_entry_t {logic [31:0] inst; logic [31:0] pc}
- One sub-module, if_prefetch_fifo: parameterized by depth and entry type, with push/pop/flush, full/empty, and registered head.

Test Plan:
- ROM word0=0x01700213, word1=0x02402023; release reset with fetch_en=1, inst_ready=1 -> cycle 2: inst=0x01700213, inst_pc=0; cycle 3: inst=0x02402023, inst_pc=4.
- Hold inst_ready=0 for 5 cycles -> exactly 2 entries buffered, pc stops at 8, head stays at pc 0; release -> pcs 0, 4, 8 delivered in order with no gaps or duplicates.
- redirect_valid with redirect_pc=0x58 while the FIFO is full and inst_ready=1 -> next cycle inst_valid=0, then inst_pc=0x58, 0x5C; err_misalign=0.
- redirect_pc=0x0000_0062 -> fetch from 0x60, err_misalign=1 and it stays set until rst_n.
- Redirect to 0x3FC, run 2 instructions -> pc 0x3FC returns the ROM word; pc 0x400 returns inst=0x00000013 and err_oob=1.
- Drop fetch_en during streaming, then assert rst_n=0 mid-handshake -> HALT drains the FIFO without new pushes; reset clears all outputs asynchronously and pc returns to RESET_PC.

Source files
------------

// File: rtl/if_pkg.sv
`default_nettype none
// ============================================================================
// Module  : if_pkg
// Brief   : Shared types and constants for the instruction-fetch block.
// Revision: 1.0
// ============================================================================
package if_pkg;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/if_fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : if_fetch_ctrl_if
// Brief   : ROM read bus plus decode valid/ready handshake of the fetch unit.
// Revision: 1.0
// ============================================================================
interface if_fetch_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int XLEN   = 32
);
  logic [ADDR_W-1:0] rom_addr;
  logic [XLEN-1:0]   rom_data;
  logic              inst_valid;
  logic [XLEN-1:0]   inst;
  logic [XLEN-1:0]   inst_pc;
  logic              inst_ready;

  modport master (
    output rom_addr,
    input  rom_data,
    output inst_valid,
    output inst,
    output inst_pc,
    input  inst_ready
  );

  modport slave (
    input  rom_addr,
    output rom_data,
    input  inst_valid,
    input  inst,
    input  inst_pc,
    output inst_ready
  );
endinterface
`default_nettype wire

// File: rtl/if_prefetch_fifo.sv
`default_nettype none
// ============================================================================
// Module  : if_prefetch_fifo
// Brief   : Small prefetch FIFO with flush; head is read straight from storage.
// Revision: 1.0
// ============================================================================
module if_prefetch_fifo
  import if_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type ENTRY_T = fetch_entry_t
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic push,
  input  ENTRY_T    push_data,
  input  wire logic pop,
  input  wire logic flush,
  output logic      full,
  output logic      empty,
  output ENTRY_T    head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  ENTRY_T           r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_count == CNT_W'(DEPTH));
  assign empty     = (r_count == '0);
  assign w_do_pop  = pop & ~empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_do_push = push & (~full | w_do_pop);
  assign head      = r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= push_data;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/if_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : if_fetch_ctrl
// Brief   : RV32I fetch sequencer: PC, ROM addressing, prefetch FIFO, redirects.
//           Optional perf counters enabled by defining IF_FETCH_PERF_EN.
// Revision: 1.0
// ============================================================================
module if_fetch_ctrl
  import if_pkg::*;
#(
  parameter int              ADDR_W     = 8,
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int              FIFO_DEPTH = 2
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  input  wire logic            fetch_en,
  if_fetch_ctrl_if.master      bus,
  input  wire logic            redirect_valid,
  input  wire logic [XLEN-1:0] redirect_pc,
  output logic                 err_misalign,
  output logic                 err_oob
`ifdef IF_FETCH_PERF_EN
  ,
  output logic [31:0]          perf_fetch_cnt,
  output logic [31:0]          perf_stall_cnt
`endif
);

  fetch_state_e    r_state;
  logic [XLEN-1:0] r_pc;
  logic            r_err_misalign;
  logic            r_err_oob;

  logic            w_full;
  logic            w_empty;
  logic            w_pop;
  logic            w_fetch;
  logic            w_oob;
  fetch_entry_t    w_push_data;
  fetch_entry_t    w_head;

  assign bus.rom_addr = r_pc[ADDR_W+1:2];
  assign w_oob        = |r_pc[XLEN-1:ADDR_W+2];

  // A redirect discards the head, so a concurrent handshake is not a pop.
  assign w_pop   = ~w_empty & bus.inst_ready & ~redirect_valid;
  assign w_fetch = (r_state == RUN) & ~redirect_valid & (~w_full | w_pop);

  assign w_push_data.inst = w_oob ? NOP_INSN : bus.rom_data;
  assign w_push_data.pc   = r_pc;

  if_prefetch_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .ENTRY_T (fetch_entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_fetch),
    .push_data (w_push_data),
    .pop       (w_pop),
    .flush     (redirect_valid),
    .full      (w_full),
    .empty     (w_empty),
    .head      (w_head)
  );

  assign bus.inst_valid = ~w_empty;
  assign bus.inst       = w_head.inst;
  assign bus.inst_pc    = w_head.pc;
  assign err_misalign   = r_err_misalign;
  assign err_oob        = r_err_oob;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= BOOT;
      r_pc           <= RESET_PC;
      r_err_misalign <= 1'b0;
      r_err_oob      <= 1'b0;
    end else begin
      case (r_state)
        BOOT:    r_state <= fetch_en ? RUN : HALT;
        RUN:     if (!fetch_en) r_state <= HALT;
        HALT:    if (fetch_en)  r_state <= RUN;
        default: r_state <= BOOT;
      endcase
      if (redirect_valid) begin
        r_pc <= {redirect_pc[XLEN-1:2], 2'b00};
        if (|redirect_pc[1:0]) r_err_misalign <= 1'b1;
      end else if (w_fetch) begin
        r_pc <= r_pc + XLEN'(4);
        if (w_oob) r_err_oob <= 1'b1;
      end
    end
  end

`ifdef IF_FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (w_fetch) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if ((r_state == RUN) && w_full && !w_pop) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_if_fetch_ctrl
// Brief   : Directed self-checking bench for if_fetch_ctrl.
// Revision: 1.0
// ============================================================================
module tb_if_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        err_misalign;
  logic        err_oob;
  logic [31:0] rom [256];
  int          checks;
  int          failures;
`ifdef IF_FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  if_fetch_ctrl_if #(.ADDR_W(8), .XLEN(32)) bus ();

  assign bus.rom_data = rom[bus.rom_addr];

  if_fetch_ctrl #(
    .ADDR_W     (8),
    .XLEN       (32),
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .bus            (bus),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .err_misalign   (err_misalign),
    .err_oob        (err_oob)
`ifdef IF_FETCH_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    for (int i = 0; i < 256; i++) rom[i] = 32'hA000_0000 + i;
    rom[0]         = 32'h0170_0213;
    rom[1]         = 32'h0240_2023;
    rst_n          = 1'b0;
    fetch_en       = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    bus.inst_ready = 1'b1;

    // Reset state
    step(); step();
    chk("rst_valid",    {31'h0, bus.inst_valid}, 32'h0);
    chk("rst_inst",     bus.inst, 32'h0);
    chk("rst_pc",       bus.inst_pc, 32'h0);
    chk("rst_misalign", {31'h0, err_misalign}, 32'h0);
    chk("rst_oob",      {31'h0, err_oob}, 32'h0);
    chk("rst_romaddr",  {24'h0, bus.rom_addr}, 32'h0);

    // First fetch latency and streaming
    rst_n = 1'b1;
    step();
    chk("boot_valid", {31'h0, bus.inst_valid}, 32'h0);
    step();
    chk("c2_valid", {31'h0, bus.inst_valid}, 32'h1);
    chk("c2_inst",  bus.inst, 32'h0170_0213);
    chk("c2_pc",    bus.inst_pc, 32'h0);
    step();
    chk("c3_inst",  bus.inst, 32'h0240_2023);
    chk("c3_pc",    bus.inst_pc, 32'h4);

    // Backpressure from reset: FIFO fills to two, pc parks at 8
    rst_n = 1'b0;
    bus.inst_ready = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("bp_valid",   {31'h0, bus.inst_valid}, 32'h1);
    chk("bp_pc",      bus.inst_pc, 32'h0);
    chk("bp_inst",    bus.inst, 32'h0170_0213);
    chk("bp_romaddr", {24'h0, bus.rom_addr}, 32'h2);
    bus.inst_ready = 1'b1;
    step();
    chk("drain_pc4", bus.inst_pc, 32'h4);
    step();
    chk("drain_pc8",   bus.inst_pc, 32'h8);
    chk("drain_inst8", bus.inst, 32'hA000_0002);

    // Redirect with a full FIFO and an accepting consumer
    redirect_valid = 1'b1;
    redirect_pc    = 32'h58;
    step();
    redirect_valid = 1'b0;
    chk("rd58_flush",   {31'h0, bus.inst_valid}, 32'h0);
    chk("rd58_romaddr", {24'h0, bus.rom_addr}, 32'h16);
    step();
    chk("rd58_pc",   bus.inst_pc, 32'h58);
    chk("rd58_inst", bus.inst, 32'hA000_0016);
    step();
    chk("rd5c_pc",       bus.inst_pc, 32'h5C);
    chk("rd5c_inst",     bus.inst, 32'hA000_0017);
    chk("rd58_misalign", {31'h0, err_misalign}, 32'h0);

    // Misaligned redirect
    redirect_valid = 1'b1;
    redirect_pc    = 32'h62;
    step();
    redirect_valid = 1'b0;
    chk("rd62_flush",    {31'h0, bus.inst_valid}, 32'h0);
    chk("rd62_misalign", {31'h0, err_misalign}, 32'h1);
    step();
    chk("rd60_pc",   bus.inst_pc, 32'h60);
    chk("rd60_inst", bus.inst, 32'hA000_0018);
    step();
    chk("misalign_sticky", {31'h0, err_misalign}, 32'h1);

    // Last ROM word then out of range
    redirect_valid = 1'b1;
    redirect_pc    = 32'h3FC;
    step();
    redirect_valid = 1'b0;
    chk("rd3fc_romaddr", {24'h0, bus.rom_addr}, 32'hFF);
    step();
    chk("pc3fc_pc",   bus.inst_pc, 32'h3FC);
    chk("pc3fc_inst", bus.inst, 32'hA000_00FF);
    chk("pc3fc_oob",  {31'h0, err_oob}, 32'h0);
    step();
    chk("pc400_pc",      bus.inst_pc, 32'h400);
    chk("pc400_inst",    bus.inst, 32'h0000_0013);
    chk("pc400_oob",     {31'h0, err_oob}, 32'h1);
    chk("pc400_romaddr", {24'h0, bus.rom_addr}, 32'h1);

    // Drop fetch_en: one more push from RUN, then HALT drains
    fetch_en = 1'b0;
    step();
    chk("halt_pc404", bus.inst_pc, 32'h404);
    step();
    chk("halt_empty",   {31'h0, bus.inst_valid}, 32'h0);
    chk("halt_romaddr", {24'h0, bus.rom_addr}, 32'h2);
    step();
    chk("halt_hold",     {31'h0, bus.inst_valid}, 32'h0);
    chk("halt_romaddr2", {24'h0, bus.rom_addr}, 32'h2);

    // Resume, then reset in the middle of a handshake
    fetch_en = 1'b1;
    step();
    step();
    chk("resume_valid", {31'h0, bus.inst_valid}, 32'h1);
    chk("resume_pc",    bus.inst_pc, 32'h408);
    chk("resume_inst",  bus.inst, 32'h0000_0013);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid",    {31'h0, bus.inst_valid}, 32'h0);
    chk("arst_inst",     bus.inst, 32'h0);
    chk("arst_pc",       bus.inst_pc, 32'h0);
    chk("arst_misalign", {31'h0, err_misalign}, 32'h0);
    chk("arst_oob",      {31'h0, err_oob}, 32'h0);
    chk("arst_romaddr",  {24'h0, bus.rom_addr}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
